dht11_sequencer: RTL and testbench

Transaction controller for the DHT11 single-wire sensor. It times every protocol phase with the team's delay tick generator, configured by this block for a 1 us strobe. It issues the host start pulse, validates the sensor response, decodes the 40-bit frame by pulse width and checks the checksum. It presents humidity/temperature registers plus status to the upper-level display/UART logic.

---
 rtl/dht11_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_dht11_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_sequencer.sv
// DHT11 single-wire transaction controller: host start pulse, response check, 40-bit pulse-width decode, checksum.
// Optional build macro DHT_RETRY_EN adds one automatic retry after no-response or bit-timeout failures.
module dht11_sequencer #(
  parameter logic [8:0]  TICK_DELAY   = 9'd49,
  parameter int unsigned START_TICKS  = 18000,
  parameter int unsigned RESP_TIMEOUT = 100,
  parameter int unsigned BIT_TIMEOUT  = 100,
  parameter int unsigned BIT_THRESH   = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  output logic [8:0] delay_cfg,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic       valid,
  output logic       error,
  output logic [1:0] err_code,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec
);

  typedef enum logic [3:0] {
    S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_DONE, S_ERR, S_RETRY_WAIT
  } state_t;

  localparam logic [14:0] START_CNT = 15'(START_TICKS);
  localparam logic [14:0] RESP_CNT  = 15'(RESP_TIMEOUT);
  localparam logic [14:0] BIT_CNT   = 15'(BIT_TIMEOUT);
  localparam logic [14:0] THR_CNT   = 15'(BIT_THRESH);

  state_t      state;
  logic        sync1, sync2, prev;
  logic        rise, fall;
  logic [14:0] cnt;
  logic [5:0]  bit_idx;
  logic [39:0] shreg;
  logic [1:0]  fail_code;
  logic [7:0]  sum;
`ifdef DHT_RETRY_EN
  logic        retried;
`endif

  assign delay_cfg = TICK_DELAY;
  assign rise      = sync2 & ~prev;
  assign fall      = ~sync2 & prev;
  assign sum       = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];

  // Synchronizer resets high to match the idle pulled-up line, so no spurious edge follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      prev      <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      fail_code <= '0;
      dht_oe    <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      error     <= 1'b0;
      err_code  <= '0;
      hum_int   <= '0;
      hum_dec   <= '0;
      temp_int  <= '0;
      temp_dec  <= '0;
`ifdef DHT_RETRY_EN
      retried   <= 1'b0;
`endif
    end else begin
      sync1 <= dht_in;
      sync2 <= sync1;
      prev  <= sync2;
      valid <= 1'b0;
      error <= 1'b0;
      if (tick && cnt != '1) cnt <= cnt + 1'b1;

      // Edge branches precede timeout branches so a coincident edge takes priority.
      case (state)
        S_IDLE: if (start) begin
          state    <= S_START_LOW;
          cnt      <= '0;
          busy     <= 1'b1;
          dht_oe   <= 1'b1;
          err_code <= '0;
        end
        S_START_LOW: if (cnt == START_CNT) begin
          state  <= S_RELEASE;
          cnt    <= '0;
          dht_oe <= 1'b0;
        end
        S_RELEASE: begin
          if (fall) begin
            state <= S_RESP_LOW;
            cnt   <= '0;
          end else if (cnt == RESP_CNT) begin
            state     <= S_ERR;
            fail_code <= 2'd1;
          end
        end
        S_RESP_LOW: begin
          if (rise) begin
            state <= S_RESP_HIGH;
            cnt   <= '0;
          end else if (cnt == RESP_CNT) begin
            state     <= S_ERR;
            fail_code <= 2'd1;
          end
        end
        S_RESP_HIGH: begin
          if (fall) begin
            state   <= S_BIT_LOW;
            cnt     <= '0;
            bit_idx <= '0;
          end else if (cnt == RESP_CNT) begin
            state     <= S_ERR;
            fail_code <= 2'd1;
          end
        end
        S_BIT_LOW: begin
          if (rise) begin
            state <= S_BIT_HIGH;
            cnt   <= '0;
          end else if (cnt == BIT_CNT) begin
            state     <= S_ERR;
            fail_code <= 2'd2;
          end
        end
        S_BIT_HIGH: begin
          if (fall) begin
            shreg <= {shreg[38:0], (cnt > THR_CNT)};
            cnt   <= '0;
            if (bit_idx == 6'd39) begin
              state <= S_CHECK;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              state   <= S_BIT_LOW;
            end
          end else if (cnt == BIT_CNT) begin
            state     <= S_ERR;
            fail_code <= 2'd2;
          end
        end
        S_CHECK: begin
          if (sum == shreg[7:0]) begin
            state <= S_DONE;
          end else begin
            state     <= S_ERR;
            fail_code <= 2'd3;
          end
        end
        S_DONE: begin
          hum_int  <= shreg[39:32];
          hum_dec  <= shreg[31:24];
          temp_int <= shreg[23:16];
          temp_dec <= shreg[15:8];
          valid    <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
`ifdef DHT_RETRY_EN
          retried  <= 1'b0;
`endif
        end
        S_ERR: begin
`ifdef DHT_RETRY_EN
          if (!retried && fail_code != 2'd3) begin
            retried <= 1'b1;
            cnt     <= '0;
            state   <= S_RETRY_WAIT;
          end else begin
            retried  <= 1'b0;
            error    <= 1'b1;
            busy     <= 1'b0;
            err_code <= fail_code;
            state    <= S_IDLE;
          end
`else
          error    <= 1'b1;
          busy     <= 1'b0;
          err_code <= fail_code;
          state    <= S_IDLE;
`endif
        end
`ifdef DHT_RETRY_EN
        S_RETRY_WAIT: if (cnt == START_CNT) begin
          state  <= S_START_LOW;
          cnt    <= '0;
          dht_oe <= 1'b1;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_sequencer.sv
// Scoreboarded bench for dht11_sequencer with a tick-aligned DHT11 sensor model on a wired-AND line.
module tb_dht11_sequencer;
  localparam int unsigned START_T = 1000;
  localparam int          BUDGET  = 30000;

  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0, start = 1'b0, sensor_lvl = 1'b1;
  logic       dht_in, dht_oe, busy, valid, error;
  logic [8:0] delay_cfg;
  logic [1:0] err_code;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;

  assign dht_in = sensor_lvl & ~dht_oe;

  dht11_sequencer #(.START_TICKS(START_T)) dut (
    .clk(clk), .rst(rst), .tick(tick), .delay_cfg(delay_cfg), .start(start),
    .dht_in(dht_in), .dht_oe(dht_oe), .busy(busy), .valid(valid), .error(error),
    .err_code(err_code), .hum_int(hum_int), .hum_dec(hum_dec),
    .temp_int(temp_int), .temp_dec(temp_dec)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); #1 tick = ~tick; end

  typedef struct packed { logic is_err; logic [1:0] code; logic [31:0] data; } exp_t;
  exp_t        sb[$];
  logic [31:0] last_good = '0;
  int n_pass = 0, n_checks = 0;
  int n_valid = 0, oe_ticks = 0, oe_rises = 0;
  logic oe_d = 1'b0;
  int hi_w[40];
  int poke_bit = -1, abort_bit = -1;

  always @(negedge clk) begin
    if (valid) n_valid++;
    if (dht_oe && tick) oe_ticks++;
    if (dht_oe && !oe_d) oe_rises++;
    oe_d = dht_oe;
  end

  // Sensor edges land in a non-tick cycle so a W-tick level spans exactly W counted ticks in the DUT.
  task automatic align();
    @(posedge clk); #2;
    if (tick) begin @(posedge clk); #2; end
  endtask

  task automatic hold(input logic lvl, input int w);
    sensor_lvl = lvl;
    repeat (2 * w) @(posedge clk);
    #2;
  endtask

  task automatic load_frame(input logic [39:0] f);
    for (int i = 0; i < 40; i++) hi_w[i] = f[39-i] ? 70 : 26;
  endtask

  task automatic sensor(output bit aborted);
    int k;
    aborted = 1'b0;
    k = 0;
    while (!dht_oe && k < 100) begin @(posedge clk); k++; end
    k = 0;
    while (dht_oe && k < 4 * START_T) begin @(posedge clk); k++; end
    if (dht_oe) return;
    align();
    hold(1'b1, 30); hold(1'b0, 80); hold(1'b1, 80);
    for (int i = 0; i < 40; i++) begin
      if (i == poke_bit) begin
        sensor_lvl = 1'b0;
        repeat (9) @(posedge clk);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (89) @(posedge clk);
        #2;
      end else begin
        hold(1'b0, 50);
      end
      if (i == abort_bit) begin
        sensor_lvl = 1'b1;
        repeat (30) @(posedge clk);
        #2;
        aborted = 1'b1;
        return;
      end
      hold(1'b1, hi_w[i]);
    end
    hold(1'b0, 50);
    sensor_lvl = 1'b1;
  endtask

  task automatic do_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_out(input int budget, output bit got, output bit v, output bit e,
                          output bit b, output int rel_ticks);
    got = 1'b0; v = 1'b0; e = 1'b0; b = 1'b1; rel_ticks = 0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (valid || error) begin
        got = 1'b1; v = valid; e = error; b = busy;
      end else if (tick && busy && !dht_oe) begin
        rel_ticks++;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (dht_oe !== 1'b0) $display("FAIL rst_dht_oe: got %b want 0", dht_oe); else n_pass++;
    n_checks++; if ({busy, valid, error} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {busy, valid, error}); else n_pass++;
    n_checks++; if (err_code !== 2'd0) $display("FAIL rst_err_code: got %0d want 0", err_code); else n_pass++;
    n_checks++; if ({hum_int, hum_dec, temp_int, temp_dec} !== 32'h0) $display("FAIL rst_data: got %h want 0", {hum_int, hum_dec, temp_int, temp_dec}); else n_pass++;
    n_checks++; if (delay_cfg !== 9'd49) $display("FAIL rst_delay_cfg: got %0d want 49", delay_cfg); else n_pass++;
    @(posedge clk); #2 rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_bad_checksum();
    bit got, v, e, b, ab; int rt; exp_t x;
    load_frame(40'h35_00_18_00_4E);
    sb.push_back('{1'b1, 2'd3, last_good});
    do_start();
    fork sensor(ab); wait_out(BUDGET, got, v, e, b, rt); join
    x = sb.pop_front();
    n_checks++; if (!got || e !== x.is_err || v !== !x.is_err) $display("FAIL cs_pulse: got valid=%b error=%b want error pulse", v, e); else n_pass++;
    n_checks++; if (err_code !== x.code) $display("FAIL cs_err_code: got %0d want %0d", err_code, x.code); else n_pass++;
    n_checks++; if ({hum_int, hum_dec, temp_int, temp_dec} !== x.data) $display("FAIL cs_data_kept: got %h want %h", {hum_int, hum_dec, temp_int, temp_dec}, x.data); else n_pass++;
  endtask

  task automatic test_good_frame();
    bit got, v, e, b, ab; int rt, t0; exp_t x;
    load_frame(40'h35_00_18_00_4D);
    last_good = 32'h35_00_18_00;
    sb.push_back('{1'b0, 2'd0, last_good});
    t0 = oe_ticks;
    do_start();
    n_checks++; if (busy !== 1'b1 || err_code !== 2'd0) $display("FAIL good_accept: got busy=%b err_code=%0d want busy=1 err_code=0", busy, err_code); else n_pass++;
    fork sensor(ab); wait_out(BUDGET, got, v, e, b, rt); join
    x = sb.pop_front();
    n_checks++; if (oe_ticks - t0 !== START_T) $display("FAIL good_start_ticks: got %0d want %0d", oe_ticks - t0, START_T); else n_pass++;
    n_checks++; if (!got || v !== !x.is_err || e !== x.is_err) $display("FAIL good_pulse: got valid=%b error=%b want valid pulse", v, e); else n_pass++;
    n_checks++; if (b !== 1'b0) $display("FAIL good_busy_at_valid: got %b want 0", b); else n_pass++;
    n_checks++; if (hum_int !== 8'd53 || temp_int !== 8'd24) $display("FAIL good_hum_temp: got %0d/%0d want 53/24", hum_int, temp_int); else n_pass++;
    n_checks++; if ({hum_int, hum_dec, temp_int, temp_dec} !== x.data || err_code !== x.code) $display("FAIL good_data: got %h code %0d want %h code %0d", {hum_int, hum_dec, temp_int, temp_dec}, err_code, x.data, x.code); else n_pass++;
  endtask

  task automatic test_no_response();
    bit got, v, e, b; int rt, r0, lo, hi, rises; exp_t x;
    sensor_lvl = 1'b1;
    sb.push_back('{1'b1, 2'd1, last_good});
    r0 = oe_rises;
    do_start();
    wait_out(BUDGET, got, v, e, b, rt);
    x = sb.pop_front();
`ifdef DHT_RETRY_EN
    lo = 200 + START_T; hi = 202 + START_T; rises = 2;
`else
    lo = 100; hi = 101; rises = 1;
`endif
    n_checks++; if (!got || e !== x.is_err || v !== !x.is_err) $display("FAIL noresp_pulse: got valid=%b error=%b want error pulse", v, e); else n_pass++;
    n_checks++; if (err_code !== x.code) $display("FAIL noresp_err_code: got %0d want %0d", err_code, x.code); else n_pass++;
    n_checks++; if (rt < lo || rt > hi) $display("FAIL noresp_ticks: got %0d want %0d..%0d", rt, lo, hi); else n_pass++;
    n_checks++; if (oe_rises - r0 !== rises) $display("FAIL noresp_start_pulses: got %0d want %0d", oe_rises - r0, rises); else n_pass++;
    n_checks++; if ({hum_int, hum_dec, temp_int, temp_dec} !== x.data) $display("FAIL noresp_data_kept: got %h want %h", {hum_int, hum_dec, temp_int, temp_dec}, x.data); else n_pass++;
  endtask

  task automatic test_widths_start_ignored();
    bit got, v, e, b, ab; int rt, nv0; exp_t x;
    load_frame(40'h60_00_1A_05_7F);
    hi_w[0] = 26; hi_w[1] = 70; hi_w[2] = 41; hi_w[3] = 40;
    poke_bit = 5;
    last_good = 32'h60_00_1A_05;
    sb.push_back('{1'b0, 2'd0, last_good});
    nv0 = n_valid;
    do_start();
    fork sensor(ab); wait_out(BUDGET, got, v, e, b, rt); join
    poke_bit = -1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    x = sb.pop_front();
    n_checks++; if (!got || v !== 1'b1 || e !== 1'b0) $display("FAIL width_pulse: got valid=%b error=%b want valid pulse", v, e); else n_pass++;
    n_checks++; if (hum_int[7:4] !== 4'b0110) $display("FAIL width_bits_26_70_41_40: got %b want 0110", hum_int[7:4]); else n_pass++;
    n_checks++; if ({hum_int, hum_dec, temp_int, temp_dec} !== x.data) $display("FAIL width_data: got %h want %h", {hum_int, hum_dec, temp_int, temp_dec}, x.data); else n_pass++;
    n_checks++; if (n_valid - nv0 !== 1 || busy !== 1'b0) $display("FAIL start_ignored: got %0d valid pulses busy=%b want 1 and 0", n_valid - nv0, busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ab; int nv0;
    load_frame(40'h35_00_18_00_4D);
    abort_bit = 20;
    nv0 = n_valid;
    do_start();
    sensor(ab);
    abort_bit = -1;
    n_checks++; if (ab !== 1'b1 || busy !== 1'b1) $display("FAIL mid_reached_bit20: got reached=%b busy=%b want 1 1", ab, busy); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (dht_oe !== 1'b0 || busy !== 1'b0) $display("FAIL mid_rst_line_busy: got oe=%b busy=%b want 0 0", dht_oe, busy); else n_pass++;
    n_checks++; if ({hum_int, hum_dec, temp_int, temp_dec} !== 32'h0) $display("FAIL mid_rst_data: got %h want 0", {hum_int, hum_dec, temp_int, temp_dec}); else n_pass++;
    n_checks++; if (n_valid - nv0 !== 0) $display("FAIL mid_no_valid: got %0d want 0", n_valid - nv0); else n_pass++;
    last_good = '0;
    @(posedge clk); #2 rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_after_reset();
    bit got, v, e, b, ab; int rt; exp_t x;
    load_frame(40'h35_00_18_00_4D);
    last_good = 32'h35_00_18_00;
    sb.push_back('{1'b0, 2'd0, last_good});
    do_start();
    fork sensor(ab); wait_out(BUDGET, got, v, e, b, rt); join
    x = sb.pop_front();
    n_checks++; if (!got || v !== 1'b1 || e !== 1'b0) $display("FAIL after_rst_pulse: got valid=%b error=%b want valid pulse", v, e); else n_pass++;
    n_checks++; if ({hum_int, hum_dec, temp_int, temp_dec} !== x.data) $display("FAIL after_rst_data: got %h want %h", {hum_int, hum_dec, temp_int, temp_dec}, x.data); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_bad_checksum();
    test_good_frame();
    test_no_response();
    test_widths_start_ignored();
    test_reset_mid();
    test_after_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: got no finish want finish before 1.2 ms");
    $fatal(1);
  end
endmodule
